adc_capture_ram_ctrl: RTL
=========================

Name: adc_capture_ram_ctrl

Overview:
Sequences ADC sample capture into the dual-port block RAM and arbitrates the RAM read port for the SPI readout logic. The block is armed by an SPI command, waits for a trigger, and writes a programmed number of consecutive valid ADC samples from address 0. It then flags completion and serves single-word read requests with fixed latency. It sits between the ADC front end, the block RAM write/read ports, and the SPI register/readout block.

Parameters:
DATA_WIDTH, 8, ADC sample width; equals block RAM word width
ADDR_BITS, 16, block RAM address width; depth = 2**ADDR_BITS

Ports:
clk  input  1  single system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
arm  input  1  one-cycle pulse: latch num_samples and enter ARMED
abort  input  1  one-cycle pulse: return to IDLE from any state
trigger  input  1  level; sampled only in ARMED
num_samples  input  ADDR_BITS  capture length; 0 = full depth 2**ADDR_BITS
adc_valid  input  1  ADC sample strobe
adc_data  input  DATA_WIDTH  ADC sample
bram_we  output  1  RAM write enable
bram_waddr  output  ADDR_BITS  RAM write address
bram_wdata  output  DATA_WIDTH  RAM write data
bram_re  output  1  RAM read enable
bram_raddr  output  ADDR_BITS  RAM read address
bram_rdata  input  DATA_WIDTH  RAM read data, valid 1 cycle after bram_re
rd_req  input  1  SPI read request, one word per asserted cycle
rd_addr  input  ADDR_BITS  SPI read address
rd_valid  output  1  read data valid
rd_data  output  DATA_WIDTH  read data
rd_reject  output  1  one-cycle pulse: rd_req refused
busy  output  1  high in ARMED or CAPTURE
done  output  1  high in DONE
captured  output  ADDR_BITS+1  samples written in the current or last capture

Behaviour:
- Reset: state IDLE. bram_we, bram_re, rd_valid, rd_reject, busy and done are 0. bram_waddr, bram_wdata, bram_raddr, rd_data and captured are 0. The latched length is 0.
- States: IDLE, ARMED, CAPTURE, DONE. busy and done are decoded from registered state.
- IDLE/DONE + arm: latch len = (num_samples==0) ? 2**ADDR_BITS : num_samples (ADDR_BITS+1 bits). Clear captured, go to ARMED. done falls the next cycle.
- arm in ARMED or CAPTURE: ignored.
- ARMED + trigger=1: go to CAPTURE in the same edge. If adc_valid=1 in that cycle, that sample is the first one written.
- Capture write path (ARMED-with-trigger or CAPTURE, adc_valid=1): next cycle bram_we=1, bram_wdata=adc_data, bram_waddr=captured[ADDR_BITS-1:0]. captured increments in the same edge.
  - Write latency is 1 cycle; bram_we is 0 when adc_valid is 0.
  - Exactly len writes occur, at addresses 0..len-1. No address wrap.
- When the accepted sample makes captured == len, go to DONE on the same edge. The final bram_we pulse occurs in the first DONE cycle. adc_valid in DONE is ignored.
- abort (any state, highest priority over arm/trigger/adc_valid): go to IDLE next edge.
  - Suppress the write for any sample presented in the abort cycle. A write already registered from the previous cycle still completes.
  - captured holds its value. done and busy are 0 after abort.
- Read arbitration:
  - rd_req is accepted only in IDLE or DONE and only when abort=0.
  - Accept: bram_re=rd_req and bram_raddr=rd_addr combinationally in the same cycle. The next cycle gives rd_valid=1 and rd_data=bram_rdata (registered).
  - Back-to-back requests give back-to-back rd_valid at 1-cycle latency.
  - rd_req in ARMED or CAPTURE: bram_re=0, rd_reject=1 next cycle, no rd_valid.
- Simultaneous arm and rd_req in IDLE/DONE: the read is accepted and the state moves to ARMED. rd_valid still follows next cycle.
- Reset asserted mid-capture: all outputs return to reset values immediately (asynchronous). RAM contents are undefined from the block's view.
- Width rule: captured and len are ADDR_BITS+1 bits, so full depth 2**ADDR_BITS is representable. The compare is exact equality.

Test Plan:
- Reset then idle: hold rst_n=0 for 3 cycles, release -> all outputs 0, done=0, busy=0; rd_req addr 5 -> bram_re=1 same cycle, rd_valid=1 next cycle with rd_data=bram_rdata.
- Basic capture: ADDR_BITS=4, num_samples=3, arm, trigger with adc_valid every cycle, data 0xA1,0xA2,0xA3 -> bram_we at addrs 0,1,2 with those data; done=1 the cycle after the 3rd sample; captured=3; a 4th sample is not written.
- Full-depth wrap boundary: ADDR_BITS=4, num_samples=0, gapped adc_valid -> exactly 16 writes, addrs 0..15, captured=16, no write to addr 0 after the 16th.
- Trigger/sample coincidence and gaps: trigger and adc_valid in the same cycle -> that sample lands at addr 0; adc_valid low before trigger -> no writes.
- Read during capture: rd_req while busy=1 -> bram_re=0, rd_reject pulse next cycle, no rd_valid; after done, 4 back-to-back reads of addrs 0..3 -> 4 consecutive rd_valid with the captured data.
- Abort mid-capture: num_samples=8, abort after the 3rd sample with adc_valid=1 in the abort cycle -> only 3 writes, state IDLE, captured=3, done=0; re-arm works and captured clears.

Source files
------------

// File: rtl/adc_capture_ram_ctrl.sv
`timescale 1ns/1ps
// ADC capture sequencer: armed by SPI, writes triggered ADC samples into block RAM from
// address 0, then serves single-word SPI reads through the RAM read port.
module adc_capture_ram_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_BITS  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  arm,
    input  logic                  abort,
    input  logic                  trigger,
    input  logic [ADDR_BITS-1:0]  num_samples,
    input  logic                  adc_valid,
    input  logic [DATA_WIDTH-1:0] adc_data,
    output logic                  bram_we,
    output logic [ADDR_BITS-1:0]  bram_waddr,
    output logic [DATA_WIDTH-1:0] bram_wdata,
    output logic                  bram_re,
    output logic [ADDR_BITS-1:0]  bram_raddr,
    input  logic [DATA_WIDTH-1:0] bram_rdata,
    input  logic                  rd_req,
    input  logic [ADDR_BITS-1:0]  rd_addr,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_reject,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_BITS:0]    captured
);
    localparam int unsigned CNT_W = ADDR_BITS + 1;
    localparam logic [CNT_W-1:0] FULL_LEN = {1'b1, {ADDR_BITS{1'b0}}};

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] len;
    logic             take;
    logic             accept;
    logic             load;
    logic             last;

    // Sample being accepted now is the final one of the programmed length.
    assign last = (captured + CNT_W'(1)) == len;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // abort overrides everything, including a sample or arm in the same cycle.
    always_comb begin
        state_next = state;
        take       = 1'b0;
        accept     = 1'b0;
        load       = 1'b0;
        case (state)
            IDLE, DONE: begin
                accept = rd_req & ~abort;
                if (arm) begin
                    load       = 1'b1;
                    state_next = ARMED;
                end
            end
            ARMED: begin
                if (trigger) begin
                    take       = adc_valid;
                    state_next = (adc_valid && last) ? DONE : CAPTURE;
                end
            end
            CAPTURE: begin
                take = adc_valid;
                if (adc_valid && last) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (abort) begin
            state_next = IDLE;
            take       = 1'b0;
            load       = 1'b0;
        end
    end

    assign bram_re    = accept;
    assign bram_raddr = accept ? rd_addr : '0;
    assign busy       = (state == ARMED) || (state == CAPTURE);
    assign done       = (state == DONE);
    // RAM read data arrives one cycle after bram_re, aligned with rd_valid.
    assign rd_data    = rd_valid ? bram_rdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bram_we    <= 1'b0;
            bram_waddr <= '0;
            bram_wdata <= '0;
            len        <= '0;
            captured   <= '0;
            rd_valid   <= 1'b0;
            rd_reject  <= 1'b0;
        end else begin
            bram_we   <= take;
            rd_valid  <= accept;
            rd_reject <= rd_req & ~accept;
            if (take) begin
                bram_waddr <= captured[ADDR_BITS-1:0];
                bram_wdata <= adc_data;
            end
            if (load) begin
                len      <= (num_samples == '0) ? FULL_LEN : {1'b0, num_samples};
                captured <= '0;
            end else if (take) begin
                captured <= captured + CNT_W'(1);
            end
        end
    end
endmodule
